// File: rtl/alu_sequencer.sv
// Issue-side controller for the 8-bit ALU: accepts reg-reg / reg-imm instructions,
// drives ALU operands from an 8x8 register file and writes the result back.
//
// state | meaning
// IDLE  | ready for an instruction; ALU inputs hold their last values
// EXEC  | ALU inputs stable; result and zero flag captured at the next edge
module alu_sequencer #(
    parameter int WIDTH = 8,
    parameter int NREGS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    input  logic [15:0]      instr,
    output logic             instr_ready,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             done,
    output logic             zero_flag,
    input  logic [2:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    typedef enum logic {IDLE, EXEC} state_t;

    state_t           state;
    state_t           state_nx;
    logic             accept;
    logic             retire;
    logic [2:0]       rd_q;
    logic [WIDTH-1:0] regs [NREGS];

    logic [2:0] op;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic       imm_sel;
    logic [2:0] imm3;

    assign op      = instr[15:13];
    assign rd      = instr[12:10];
    assign rs1     = instr[9:7];
    assign rs2     = instr[6:4];
    assign imm_sel = instr[3];
    assign imm3    = instr[2:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        instr_ready = 1'b0;
        accept      = 1'b0;
        retire      = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = ~rst;
                if (instr_valid && !rst) begin
                    accept   = 1'b1;
                    state_nx = EXEC;
                end
            end
            EXEC: begin
                retire   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Reset abandons an in-flight instruction: no write-back and no done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a       <= '0;
            alu_b       <= '0;
            alu_control <= 3'b000;
            rd_q        <= 3'd0;
            done        <= 1'b0;
            zero_flag   <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            done <= retire;
            if (accept) begin
                alu_a       <= (rs1 == 3'd0) ? '0 : regs[rs1];
                alu_b       <= imm_sel ? {{(WIDTH-3){1'b0}}, imm3}
                                       : ((rs2 == 3'd0) ? '0 : regs[rs2]);
                alu_control <= op;
                rd_q        <= rd;
            end
            if (retire) begin
                zero_flag <= alu_zero;
                if (rd_q != 3'd0) begin
                    regs[rd_q] <= alu_result;
                end
            end
        end
    end

    assign dbg_data = (dbg_addr == 3'd0) ? '0 : regs[dbg_addr];

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Issue-side controller for the 8-bit ALU. It accepts 16-bit register-register and register-immediate instructions over a valid/ready handshake and holds an 8×8 register file. For each accepted instruction it drives the ALU operand and function-select inputs, captures the ALU result and zero output, and writes the result back. It sits between instruction fetch/decode and the ALU, and is the initiator of the ALU's `a`/`b`/`alu_control` → `result`/`zero` interface.

## Interface
- `WIDTH`, 8: datapath width. Fixed at 8 for this design; other values are unsupported.
- `NREGS`, 8: register count. Register addresses are 3 bits.
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `instr_valid` input 1: `instr` is valid this cycle.
- `instr` input 16: instruction word.
  - [15:13] `op`: passed unchanged to the ALU function select.
  - [12:10] `rd`: destination register.
  - [9:7] `rs1`: first source register.
  - [6:4] `rs2`: second source register.
  - [3] `imm_sel`: selects the immediate as operand b.
  - [2:0] `imm3`: 3-bit immediate.
- `instr_ready` output 1: the block can accept an instruction this cycle.
- `alu_a` output 8: ALU operand a.
- `alu_b` output 8: ALU operand b.
- `alu_control` output 3: ALU function select.
- `alu_result` input 8: ALU result. Combinational from `alu_a`, `alu_b` and `alu_control`.
- `alu_zero` input 1: ALU zero flag.
- `done` output 1: one-cycle pulse on instruction retirement.
- `zero_flag` output 1: `alu_zero` value from the last retired instruction.
- `dbg_addr` input 3: debug read address.
- `dbg_data` output 8: combinational register-file read at `dbg_addr`.

## Operation
- States: `IDLE` and `EXEC`.
- `IDLE`:
  - `instr_ready` = 1.
  - On `instr_valid && instr_ready` at an edge, the block latches `rd` and loads `alu_a` = R[rs1].
  - `alu_b` loads `{5'b0, imm3}` if `imm_sel`, else R[rs2].
  - `alu_control` loads `op`.
  - Next state is `EXEC`.
- `EXEC`:
  - `instr_ready` = 0. `instr_valid` is ignored.
  - At the next edge, `alu_result` is written to R[rd] (except when rd = 0).
  - `zero_flag` is loaded with `alu_zero`, `done` is set to 1 for the following cycle, and next state is `IDLE`.
- R0 always reads 0. Writes to R0 are discarded, but `zero_flag` and `done` still update.
- `alu_a`, `alu_b` and `alu_control` hold their last values in `IDLE`. They are only meaningful in `EXEC`.
- No arithmetic is done inside this block. Result width is 8 bits. Carry and borrow are not observed.
- `dbg_data` is a combinational read of R[dbg_addr] and returns 0 for address 0.

## Timing
- Reset (`rst` high at an edge):
  - State goes to `IDLE`.
  - R0..R7 = 0.
  - `alu_a` = 0, `alu_b` = 0, `alu_control` = 3'b000.
  - `done` = 0, `zero_flag` = 0.
  - `instr_ready` = 0 while `rst` is high, and 1 in the first cycle after `rst` deasserts.
- Accept edge E0: operands are registered from the register file state as it stands before E0.
- Cycle E0→E1: ALU inputs are stable and the ALU settles combinationally.
- Edge E1: register write-back, `zero_flag` update and return to `IDLE`.
- Cycle E1→E2: `done` = 1 and `instr_ready` = 1.
- Throughput is one instruction per 2 cycles. Retire latency is 2 edges from accept.
- Back-to-back read-after-write: an instruction accepted at E2 reads R[rd] as written at E1. No forwarding or stall is needed.
- `instr_valid` high while `instr_ready` = 0: no effect. The source holds the instruction until it is accepted.
- `rst` asserted while in `EXEC`: the instruction is abandoned. No write, no `done`, full reset values apply.
- `rst` and `instr_valid` high in the same cycle: reset wins and nothing is accepted.

## Test plan
- Reset, then R1 = R0 + imm 5 (op 000, rd 1, rs1 0, `imm_sel` 1, `imm3` 5) → `done` 1 exactly 2 edges after accept, `dbg_data`[1] = 0x05, `zero_flag` = 0.
- R2 = R1 − R1 (op 001) → R2 = 0x00 and `zero_flag` = 1. Then R3 = R1 << imm 3 (op 011) → R3 = 0x28, `zero_flag` = 0.
- R4 = ~R1 (op 010) → 0xFA. R5 = R4 ^ R1 (op 111) → 0xFF. R6 = R5 >> imm 4 (op 100) → 0x0F.
- Instruction with rd = 0 and result 0x05 → `dbg_data`[0] stays 0x00, `done` still pulses, `zero_flag` = 0.
- `instr_valid` held high with back-to-back instructions: R1 = R0 + 7, then R2 = R1 + R1 → `instr_ready` alternates 1/0, final R2 = 0x0E, no instruction lost or duplicated.
- `rst` pulsed during `EXEC` of R7 = R0 + 6 → no `done`, R7 = 0, all outputs at reset values, first instruction after reset accepted normally.
